// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse state enum, character codes and timing thresholds
//
// Contents:
//   morse_state_t : receiver FSM states (IDLE, MARK, SPACE, EMIT)
//   CH_0..CH_9, CH_A..CH_Z : 6-bit character codes shared with the transmitter
//   DOT_MAX_HALF, DASH_MAX_HALF, CHAR_GAP_HALF : thresholds in half-unit ticks
//   MAX_SYMBOLS : longest legal symbol sequence
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        EMIT  = 2'd3
    } morse_state_t;

    localparam logic [5:0] CH_0 = 6'd0,  CH_1 = 6'd1,  CH_2 = 6'd2,  CH_3 = 6'd3;
    localparam logic [5:0] CH_4 = 6'd4,  CH_5 = 6'd5,  CH_6 = 6'd6,  CH_7 = 6'd7;
    localparam logic [5:0] CH_8 = 6'd8,  CH_9 = 6'd9;
    localparam logic [5:0] CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13;
    localparam logic [5:0] CH_E = 6'd14, CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17;
    localparam logic [5:0] CH_I = 6'd18, CH_J = 6'd19, CH_K = 6'd20, CH_L = 6'd21;
    localparam logic [5:0] CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24, CH_P = 6'd25;
    localparam logic [5:0] CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
    localparam logic [5:0] CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33;
    localparam logic [5:0] CH_Y = 6'd34, CH_Z = 6'd35;

    localparam logic [3:0] DOT_MAX_HALF  = 4'd3;
    localparam logic [3:0] DASH_MAX_HALF = 4'd13;
    localparam logic [3:0] CHAR_GAP_HALF = 4'd4;
    localparam logic [2:0] MAX_SYMBOLS   = 3'd5;

endpackage

// File: rtl/morse_symbol_lookup.sv
// rtl/morse_symbol_lookup.sv - combinational (count, symbols) to character code map
//
// Ports:
//   n     in  3  number of received symbols (0-5)
//   sym   in  5  symbols, first received in bit n-1; 0 = dot, 1 = dash
//   legal out 1  high when (n, sym) names one of the 36 characters
//   code  out 6  character code, 0 when not legal
import morse_pkg::*;

module morse_symbol_lookup (
    input  logic [2:0] n,
    input  logic [4:0] sym,
    output logic       legal,
    output logic [5:0] code
);

    always_comb begin
        legal = 1'b1;
        code  = 6'd0;
        case ({n, sym})
            8'b001_00000: code = CH_E;
            8'b001_00001: code = CH_T;
            8'b010_00000: code = CH_I;
            8'b010_00001: code = CH_A;
            8'b010_00010: code = CH_N;
            8'b010_00011: code = CH_M;
            8'b011_00000: code = CH_S;
            8'b011_00001: code = CH_U;
            8'b011_00010: code = CH_R;
            8'b011_00011: code = CH_W;
            8'b011_00100: code = CH_D;
            8'b011_00101: code = CH_K;
            8'b011_00110: code = CH_G;
            8'b011_00111: code = CH_O;
            8'b100_00000: code = CH_H;
            8'b100_00001: code = CH_V;
            8'b100_00010: code = CH_F;
            8'b100_00100: code = CH_L;
            8'b100_00110: code = CH_P;
            8'b100_00111: code = CH_J;
            8'b100_01000: code = CH_B;
            8'b100_01001: code = CH_X;
            8'b100_01010: code = CH_C;
            8'b100_01011: code = CH_Y;
            8'b100_01100: code = CH_Z;
            8'b100_01101: code = CH_Q;
            8'b101_00000: code = CH_5;
            8'b101_00001: code = CH_4;
            8'b101_00011: code = CH_3;
            8'b101_00111: code = CH_2;
            8'b101_01111: code = CH_1;
            8'b101_10000: code = CH_6;
            8'b101_11000: code = CH_7;
            8'b101_11100: code = CH_8;
            8'b101_11110: code = CH_9;
            8'b101_11111: code = CH_0;
            default:      legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_code_receiver.sv
// rtl/morse_code_receiver.sv - Morse line decoder producing 6-bit character codes
//
// Optional feature macro: MORSE_DEBOUNCE_EN (adds a DEBOUNCE_CYCLES debouncer after the synchronizer).
//
// Parameters:
//   UNIT_CYCLES      clock cycles per Morse unit (even, >= 4)
//   DEBOUNCE_CYCLES  stable cycles before a level change is accepted (debounce build only)
// Ports:
//   CLOCK_50    in  1  system clock
//   RESET       in  1  synchronous active-high reset
//   MORSE_IN    in  1  raw asynchronous Morse line, 1 = mark
//   CHAR_OUT    out 6  last legal decoded character
//   CHAR_VALID  out 1  one-cycle pulse when CHAR_OUT is updated
//   CHAR_ERROR  out 1  one-cycle pulse when a character ends illegally
//   BUSY        out 1  high while a character is in progress
import morse_pkg::*;

module morse_code_receiver #(
    parameter int UNIT_CYCLES     = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       MORSE_IN,
    output logic [5:0] CHAR_OUT,
    output logic       CHAR_VALID,
    output logic       CHAR_ERROR,
    output logic       BUSY
);

    localparam int HALF = UNIT_CYCLES / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic          sync_1, sync_2;
    logic          line, line_d;
    logic          line_edge, tick;
    logic [CW-1:0] pre_cnt;
    logic [3:0]    run;
    morse_state_t  state;
    logic [4:0]    sym;
    logic [2:0]    n;
    logic          err;
    logic          lk_legal;
    logic [5:0]    lk_code;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= MORSE_IN;
            sync_2 <= sync_1;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] db_cnt;
    logic          db_line;

    // The counter only runs while the synchronized level disagrees with LINE;
    // any return to agreement restarts the qualification.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            db_cnt  <= '0;
            db_line <= 1'b0;
        end else if (sync_2 != db_line) begin
            if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_line <= sync_2;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign line = db_line;
`else
    wire unused_debounce = (DEBOUNCE_CYCLES != 0);
    assign line = sync_2;
`endif

    assign line_edge = line ^ line_d;
    assign tick      = (pre_cnt == HALF_LAST);

    // Half-unit prescaler and saturating run counter, both restarted by any edge
    // so RUN always measures the current mark or space.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            line_d  <= 1'b0;
            pre_cnt <= '0;
            run     <= 4'd0;
        end else begin
            line_d <= line;
            if (line_edge) begin
                pre_cnt <= '0;
                run     <= 4'd0;
            end else if (tick) begin
                pre_cnt <= '0;
                if (run != 4'd15) begin
                    run <= run + 4'd1;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    morse_symbol_lookup u_lookup (
        .n     (n),
        .sym   (sym),
        .legal (lk_legal),
        .code  (lk_code)
    );

    // The character result is registered on the SPACE->EMIT transition, so the
    // pulse is visible while the state is EMIT, 2*UNIT_CYCLES+1 cycles after the fall.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state      <= IDLE;
            sym        <= 5'd0;
            n          <= 3'd0;
            err        <= 1'b0;
            CHAR_OUT   <= 6'd0;
            CHAR_VALID <= 1'b0;
            CHAR_ERROR <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            CHAR_VALID <= 1'b0;
            CHAR_ERROR <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_edge && line) begin
                        state <= MARK;
                        BUSY  <= 1'b1;
                    end
                end
                MARK: begin
                    if (line_edge && !line) begin
                        state <= SPACE;
                        if (run == 4'd0) begin
                            // Glitch: only abandon the character if nothing was collected.
                            if (n == 3'd0 && !err) begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                            end
                        end else if (run > DASH_MAX_HALF) begin
                            err <= 1'b1;
                        end else if (n == MAX_SYMBOLS) begin
                            err <= 1'b1;
                        end else begin
                            sym <= {sym[3:0], (run > DOT_MAX_HALF)};
                            n   <= n + 3'd1;
                        end
                    end
                end
                SPACE: begin
                    // The gap check wins over a simultaneous rising edge.
                    if (tick && run == CHAR_GAP_HALF - 4'd1) begin
                        state <= EMIT;
                        if (err || !lk_legal) begin
                            CHAR_ERROR <= 1'b1;
                        end else begin
                            CHAR_OUT   <= lk_code;
                            CHAR_VALID <= 1'b1;
                        end
                    end else if (line_edge && line) begin
                        state <= MARK;
                    end
                end
                EMIT: begin
                    sym <= 5'd0;
                    n   <= 3'd0;
                    err <= 1'b0;
                    if (line) begin
                        state <= MARK;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_code_receiver.sv
// tb/tb_morse_code_receiver.sv - directed self-checking bench for morse_code_receiver
module tb_morse_code_receiver;

    localparam int UNIT = 8;
`ifdef MORSE_DEBOUNCE_EN
    localparam int LAT = 2 + 3;
`else
    localparam int LAT = 2;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       MORSE_IN = 1'b0;
    logic [5:0] CHAR_OUT;
    logic       CHAR_VALID;
    logic       CHAR_ERROR;
    logic       BUSY;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int t0;
    int busy_seen = 0;
    int c0, c1;
    int valid_q[$];

    morse_code_receiver #(
        .UNIT_CYCLES     (UNIT),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .MORSE_IN   (MORSE_IN),
        .CHAR_OUT   (CHAR_OUT),
        .CHAR_VALID (CHAR_VALID),
        .CHAR_ERROR (CHAR_ERROR),
        .BUSY       (BUSY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc = cyc + 1;

    always @(negedge CLOCK_50) begin
        if (CHAR_VALID) begin
            valid_q.push_back(int'(CHAR_OUT));
            valid_cyc = cyc;
        end
        if (CHAR_ERROR) err_cnt = err_cnt + 1;
        if (BUSY) busy_seen = 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int k);
        MORSE_IN = v;
        repeat (k) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_log();
        valid_q.delete();
        err_cnt   = 0;
        busy_seen = 0;
    endtask

    task automatic dot();
        hold(1'b1, 8);
        hold(1'b0, 8);
    endtask

    task automatic dash();
        hold(1'b1, 24);
        hold(1'b0, 8);
    endtask

    initial begin
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_char_out", int'(CHAR_OUT), 0);
        check("reset_valid", int'(CHAR_VALID), 0);
        check("reset_error", int'(CHAR_ERROR), 0);
        check("reset_busy", int'(BUSY), 0);
        RESET = 1'b0;
        hold(1'b0, 4);

        // 'E' with latency measured from the MORSE_IN fall
        clear_log();
        hold(1'b1, 8);
        t0 = cyc;
        hold(1'b0, 40);
        check("e_count", valid_q.size(), 1);
        check("e_code", (valid_q.size() > 0) ? valid_q[0] : -1, 14);
        check("e_latency", valid_cyc - t0, 17 + LAT);
        check("e_no_error", err_cnt, 0);
        check("e_idle", int'(BUSY), 0);

        // 'A'
        clear_log();
        hold(1'b1, 8);
        check("a_busy", int'(BUSY), 1);
        hold(1'b0, 8);
        hold(1'b1, 24);
        hold(1'b0, 40);
        check("a_count", valid_q.size(), 1);
        check("a_code", (valid_q.size() > 0) ? valid_q[0] : -1, 10);

        // six dots: error, CHAR_OUT keeps 'A'
        clear_log();
        repeat (6) dot();
        hold(1'b0, 40);
        check("six_err", err_cnt, 1);
        check("six_novalid", valid_q.size(), 0);
        check("six_hold_out", int'(CHAR_OUT), 10);

        // unmapped ..-..
        clear_log();
        dot(); dot(); dash(); dot(); dot();
        hold(1'b0, 40);
        check("unmap_err", err_cnt, 1);
        check("unmap_novalid", valid_q.size(), 0);
        check("unmap_hold_out", int'(CHAR_OUT), 10);

        // '0' as five dashes
        clear_log();
        repeat (5) dash();
        hold(1'b0, 40);
        check("zero_count", valid_q.size(), 1);
        check("zero_code", (valid_q.size() > 0) ? valid_q[0] : -1, 0);

        // overlong mark
        clear_log();
        hold(1'b1, 120);
        hold(1'b0, 40);
        check("long_err", err_cnt, 1);
        check("long_novalid", valid_q.size(), 0);

        // 2-cycle glitch
        clear_log();
        hold(1'b1, 2);
        hold(1'b0, 40);
`ifdef MORSE_DEBOUNCE_EN
        check("glitch_busy_seen", busy_seen, 0);
`else
        check("glitch_busy_seen", busy_seen, 1);
`endif
        check("glitch_idle", int'(BUSY), 0);
        check("glitch_no_pulse", err_cnt + valid_q.size(), 0);

        // 'S' then 'T' with a 16-cycle gap (emit wins over the rising edge)
        clear_log();
        hold(1'b1, 8); hold(1'b0, 8);
        hold(1'b1, 8); hold(1'b0, 8);
        hold(1'b1, 8); hold(1'b0, 16);
        hold(1'b1, 24);
        hold(1'b0, 40);
        c0 = (valid_q.size() > 0) ? valid_q[0] : -1;
        c1 = (valid_q.size() > 1) ? valid_q[1] : -1;
        check("st_count", valid_q.size(), 2);
        check("st_first", c0, 28);
        check("st_second", c1, 29);
        check("st_no_error", err_cnt, 0);

        // reset in the middle of a 'T' mark
        clear_log();
        hold(1'b1, 10);
        RESET    = 1'b1;
        MORSE_IN = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("rst_char_out", int'(CHAR_OUT), 0);
        check("rst_valid", int'(CHAR_VALID), 0);
        check("rst_error", int'(CHAR_ERROR), 0);
        check("rst_busy", int'(BUSY), 0);
        RESET = 1'b0;
        clear_log();
        hold(1'b0, 40);
        check("rst_no_pulse", err_cnt + valid_q.size(), 0);
        check("rst_idle", int'(BUSY), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
